// File: rtl/convcor_gen.sv
// -----------------------------------------------------------------------------
// convcor_gen
//   Loads two signed sequences a[0..N-1] and b[0..N-1], one element pair per
//   in_valid cycle. Then it streams either their full linear convolution
//   (mode 0) or their full cross-correlation (mode 1). The output is 2N-1
//   results, one per cycle, at full precision.
//
// Parameters
//   DW   signed element width (4..16)
//   N    sequence length (2..16)
//   OW   result width, 2*DW + clog2(N); wide enough that no sum can overflow
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   qualifies in_a / in_b / in_mode (ignored while busy)
//   in_a       signed element of sequence a
//   in_b       signed element of sequence b
//   in_mode    0 = convolution, 1 = cross-correlation (sampled on first element)
//   out_valid  registered, high for 2N-1 cycles per transaction
//   out        registered signed result, zero whenever out_valid is low
// -----------------------------------------------------------------------------
module convcor_gen #(
    parameter int DW = 8,
    parameter int N  = 3,
    parameter int OW = 2*DW + $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_a,
    input  logic signed [DW-1:0] in_b,
    input  logic                 in_mode,
    output logic                 out_valid,
    output logic signed [OW-1:0] out
);

    localparam int LW = $clog2(N);        // sample index width
    localparam int KW = $clog2(2*N - 1);  // result index width
    localparam int PW = 2*DW;             // product width

    typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic signed [DW-1:0]  r_a [N];
    logic signed [DW-1:0]  r_b [N];
    logic                  r_mode;
    logic [LW-1:0]         r_cnt;
    logic [KW-1:0]         r_k;
    logic                  r_valid;
    logic signed [OW-1:0]  r_out;

    logic                  w_load_last;
    logic                  w_out_last;
    logic signed [OW-1:0]  w_acc;
    logic                  w_valid_nxt;
    logic signed [OW-1:0]  w_out_nxt;

    assign w_load_last = (r_state == LOAD) && in_valid && (r_cnt == LW'(N - 1));
    assign w_out_last  = (r_k == KW'(2*N - 2));

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------- next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (in_valid) w_state_nxt = LOAD;
            LOAD: begin
                // A gap in the element stream aborts the whole transaction.
                if (!in_valid)        w_state_nxt = IDLE;
                else if (w_load_last) w_state_nxt = CALC;
            end
            CALC: w_state_nxt = OUT;
            OUT:  if (w_out_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Result k as a sum of products over every in-range index pair.
    // Convolution pairs a[i] with b[k-i]. Correlation pairs a[i] with
    // b[i+k-(N-1)], so that lag -(N-1) comes out first.
    always_comb begin
        w_acc = '0;
        for (int i = 0; i < N; i++) begin
            automatic int                   j;
            automatic logic signed [PW-1:0] prod;
            j    = r_mode ? (i + int'(r_k) - (N - 1)) : (int'(r_k) - i);
            prod = '0;
            if (j >= 0 && j < N) begin
                prod  = r_a[i[LW-1:0]] * r_b[j[LW-1:0]];
                w_acc = w_acc + OW'(prod);
            end
        end
    end

    // ---------------------------------------------------------------- output logic
    always_comb begin
        w_valid_nxt = 1'b0;
        w_out_nxt   = '0;
        if (r_state == OUT) begin
            w_valid_nxt = 1'b1;
            w_out_nxt   = w_acc;
        end
    end

    // ---------------------------------------------------------------- sample / counter / output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
            end
            r_mode  <= 1'b0;
            r_cnt   <= '0;
            r_k     <= '0;
            r_valid <= 1'b0;
            r_out   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        // Wipe old samples so nothing from a previous run survives.
                        for (int i = 1; i < N; i++) begin
                            r_a[i] <= '0;
                            r_b[i] <= '0;
                        end
                        r_a[0] <= in_a;
                        r_b[0] <= in_b;
                        r_mode <= in_mode;
                        r_cnt  <= LW'(1);
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        r_a[r_cnt] <= in_a;
                        r_b[r_cnt] <= in_b;
                        r_cnt      <= w_load_last ? '0 : r_cnt + LW'(1);
                    end else begin
                        for (int i = 0; i < N; i++) begin
                            r_a[i] <= '0;
                            r_b[i] <= '0;
                        end
                        r_cnt <= '0;
                    end
                end
                CALC: r_k <= '0;
                OUT:  r_k <= w_out_last ? '0 : r_k + KW'(1);
                default: r_cnt <= '0;
            endcase
            r_valid <= w_valid_nxt;
            r_out   <= w_out_nxt;
        end
    end

    assign out_valid = r_valid;
    assign out       = r_out;

endmodule

// File: tb/tb_convcor_gen.sv
// -----------------------------------------------------------------------------
// tb_convcor_gen
//   Directed and randomized transactions for convcor_gen (DW=8, N=3). Expected
//   results come from a pair-wise sum-of-products reference model, or from
//   fixed tables for the hand-worked vectors.
// -----------------------------------------------------------------------------
module tb_convcor_gen;

    localparam int DW = 8;
    localparam int N  = 3;
    localparam int OW = 2*DW + $clog2(N);
    localparam int NR = 2*N - 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic signed [DW-1:0] in_a;
    logic signed [DW-1:0] in_b;
    logic                 in_mode;
    logic                 out_valid;
    logic signed [OW-1:0] out;

    int n_checks = 0;
    int n_pass   = 0;
    int sa [N];
    int sb [N];
    int exp_r [NR];

    convcor_gen #(.DW(DW), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out       (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: visit every (i, j) pair and add a[i]*b[j] into the
    // result slot that the pair belongs to.
    task automatic model_fill(input bit mode);
        for (int k = 0; k < NR; k++) exp_r[k] = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                if (mode == 1'b0) exp_r[i + j] += sa[i] * sb[j];
                else              exp_r[j - i + (N - 1)] += sa[i] * sb[j];
            end
    endtask

    task automatic run_txn(input bit mode, input bit busy, input string tag);
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_a     = DW'(sa[i]);
            in_b     = DW'(sb[i]);
            in_mode  = (i == 0) ? mode : ~mode;
            tick();
        end
        in_valid = 1'b0;
        in_a     = DW'($urandom);
        in_b     = DW'($urandom);
        check($sformatf("%s valid@t", tag), out_valid, 0);
        tick();
        check($sformatf("%s valid@t+1", tag), out_valid, 0);
        for (int k = 0; k < NR; k++) begin
            tick();
            check($sformatf("%s valid k%0d", tag, k), out_valid, 1);
            check($sformatf("%s out k%0d", tag, k), out, exp_r[k]);
            if (busy && k < 2) begin
                in_valid = 1'b1;
                in_a     = 8'sd9;
                in_b     = 8'sd9;
                in_mode  = ~mode;
            end else begin
                in_valid = 1'b0;
            end
        end
        tick();
        check($sformatf("%s valid end", tag), out_valid, 0);
        check($sformatf("%s out end", tag), out, 0);
    endtask

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_mode  = 1'b0;

        // Asynchronous reset, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("reset valid", out_valid, 0);
        check("reset out", out, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Hand-worked convolution and back-to-back correlation.
        sa = '{1, 2, 3};
        sb = '{4, 5, 6};
        exp_r = '{4, 13, 28, 27, 18};
        run_txn(1'b0, 1'b0, "conv");
        exp_r = '{12, 23, 32, 17, 6};
        run_txn(1'b1, 1'b0, "corr");

        // Extreme values.
        sa = '{-128, -128, -128};
        sb = '{-128, -128, -128};
        exp_r = '{16384, 32768, 49152, 32768, 16384};
        run_txn(1'b0, 1'b0, "ext_nn");
        sb = '{127, 127, 127};
        exp_r = '{-16256, -32512, -48768, -32512, -16256};
        run_txn(1'b0, 1'b0, "ext_np");

        // Aborted load: two elements, then a gap.
        in_valid = 1'b1;
        in_a     = 8'sd7;
        in_b     = 8'sd7;
        tick();
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            check($sformatf("abort valid c%0d", c), out_valid, 0);
        end
        sa = '{1, 2, 3};
        sb = '{4, 5, 6};
        exp_r = '{4, 13, 28, 27, 18};
        run_txn(1'b0, 1'b0, "post_abort");

        // Input activity while busy, then back-to-back correlation.
        run_txn(1'b0, 1'b1, "busy_conv");
        exp_r = '{12, 23, 32, 17, 6};
        run_txn(1'b1, 1'b0, "b2b_corr");

        // Randomized transactions against the reference model.
        for (int t = 0; t < 8; t++) begin
            automatic bit mode = 1'($urandom);
            for (int i = 0; i < N; i++) begin
                sa[i] = ($urandom_range(0, 3) == 0) ? -128 : int'($signed(DW'($urandom)));
                sb[i] = ($urandom_range(0, 3) == 0) ? 127  : int'($signed(DW'($urandom)));
            end
            model_fill(mode);
            run_txn(mode, 1'($urandom), $sformatf("rand%0d", t));
        end

        // Reset during the second result.
        sa = '{1, 2, 3};
        sb = '{4, 5, 6};
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_a     = DW'(sa[i]);
            in_b     = DW'(sb[i]);
            in_mode  = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("rstmid out k0", out, 4);
        tick();
        check("rstmid out k1", out, 13);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid valid async", out_valid, 0);
        check("rstmid out async", out, 0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("rstmid quiet c%0d", c), out_valid, 0);
        end

        // First transaction after reset.
        sa = '{-3, 7, 100};
        sb = '{-50, 2, -1};
        model_fill(1'b1);
        run_txn(1'b1, 1'b0, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
